// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N-input, WIDTH-bit multiplexer with per-channel
// valid/ready handshakes and a one-stage output register.
//   mode = 0 : the channel is chosen by sel (direct select)
//   mode = 1 : the channel is chosen by a round-robin search starting at rr_ptr
// At most one channel transfers per cycle. A transfer happens when the output
// stage is empty or draining this cycle (accept) and the granted channel is valid.
module mux_n_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   IN,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     OUT,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Channel indices are SELW bits wide. When N is not a power of two, some
    // index values name no channel, so valid bits are padded to the full
    // index space and the padding reads as "not valid".
    localparam int          NP     = 1 << SELW;
    localparam int unsigned N_U    = N;
    localparam logic [SELW:0]   N_W    = N_U[SELW:0];
    localparam logic [SELW-1:0] LAST_CH = N_U[SELW-1:0] - 1'b1;

    // Output stage and round-robin pointer registers.
    logic [WIDTH-1:0] out_q,       out_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    // Arbitration results.
    logic [NP-1:0]    in_valid_pad;
    logic             accept;
    logic             sel_in_range;
    logic             rr_found;
    logic [SELW-1:0]  rr_grant;
    logic [SELW:0]    rr_idx;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // Zero-extend the valid vector so any SELW-bit index can address it safely.
    always_comb begin
        in_valid_pad        = '0;
        in_valid_pad[N-1:0] = in_valid;
    end

    // The output stage can take a new word when it is empty or being drained.
    always_comb begin
        accept = !out_valid_q || out_ready;
    end

    // Round-robin search: first valid channel at rr_ptr, rr_ptr+1, ... wrapping
    // past N-1 back to 0. rr_ptr is always below N, so one subtraction of N
    // is enough to bring the running index back into range.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
            if (rr_idx >= N_W) begin
                rr_idx = rr_idx - N_W;
            end
            if (!rr_found && in_valid_pad[rr_idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx[SELW-1:0];
            end
        end
    end

    // Grant selection: direct mode trusts sel only when it names a real channel.
    always_comb begin
        sel_in_range = ({1'b0, sel} < N_W);
        if (mode) begin
            grant       = rr_grant;
            grant_valid = rr_found;
        end else begin
            grant       = sel;
            grant_valid = sel_in_range && in_valid_pad[sel];
        end
    end

    // Data mux for the granted channel; out-of-range grants never transfer,
    // so their zero default is never loaded.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = IN[i*WIDTH +: WIDTH];
            end
        end
    end

    // Per-channel ready: only the granted channel sees ready, and nobody does
    // while reset is held.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && accept && grant_valid && (grant == SELW'(i));
        end
    end

    // Next-state for the output stage and round-robin pointer.
    always_comb begin
        xfer        = accept && grant_valid;
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_d     = grant_data;
                out_sel_d = grant;
            end
        end
        if (xfer && mode) begin
            rr_ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
        end
    end

    // State registers; reset empties the output stage immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign OUT       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed testbench for mux_n_pipe: a default N=4 instance and an N=3
// instance for the out-of-range select case.
module tb_mux_n_pipe;

    logic        clk;
    logic        rst;

    // N=4, WIDTH=8 instance
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    // N=3, WIDTH=8 instance
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int checks = 0;
    int errors = 0;

    mux_n_pipe #(.WIDTH(8), .N(4)) u4 (
        .clk(clk), .rst(rst), .IN(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .OUT(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n_pipe #(.WIDTH(8), .N(3)) u3 (
        .clk(clk), .rst(rst), .IN(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .OUT(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] s, input logic v);
        chk({tag, "_out"},   out_data,  d);
        chk({tag, "_sel"},   out_sel,   s);
        chk({tag, "_valid"}, out_valid, v);
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 4'hF;
        sel        = 2'd0;
        mode       = 1'b1;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = '0;
        sel3       = 2'd0;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // Reset state: outputs cleared and no ready even with valid inputs.
        #2;
        chk_out("reset", 8'h00, 2'd0, 1'b0);
        chk("reset_in_ready", in_ready, 4'b0000);
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 4'b0000;
        mode     = 1'b0;
        #1;

        // Direct mode: sel=2, ch2=A5.
        sel      = 2'd2;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        in_valid = 4'b0100;
        #1;
        chk("direct_in_ready", in_ready, 4'b0100);
        tick();
        chk_out("direct", 8'hA5, 2'd2, 1'b1);

        // Select a channel with no valid: output drains, data holds.
        sel      = 2'd1;
        in_valid = 4'b0000;
        #1;
        chk("direct_idle_in_ready", in_ready, 4'b0000);
        tick();
        chk_out("direct_idle", 8'hA5, 2'd2, 1'b0);

        // Backpressure: load 3C, then hold out_ready low with new data waiting.
        sel      = 2'd2;
        in_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
        in_valid = 4'b0100;
        tick();
        chk_out("bp_load", 8'h3C, 2'd2, 1'b1);
        out_ready = 1'b0;
        in_data   = {8'h00, 8'h77, 8'h00, 8'h00};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", in_ready, 4'b0000);
            tick();
            chk_out("bp_hold", 8'h3C, 2'd2, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 4'b0100);
        tick();
        chk_out("bp_release", 8'h77, 2'd2, 1'b1);
        in_valid = 4'b0000;
        tick();
        chk("bp_drain_valid", out_valid, 1'b0);

        // Round-robin fairness: all channels valid, rr_ptr starts at 0.
        mode     = 1'b1;
        sel      = 2'd3;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        #1;
        chk("rr_first_in_ready", in_ready, 4'b0001);
        tick();
        chk_out("rr0", 8'h10, 2'd0, 1'b1);
        chk("rr_second_in_ready", in_ready, 4'b0010);
        tick();
        chk_out("rr1", 8'h11, 2'd1, 1'b1);
        tick();
        chk_out("rr2", 8'h12, 2'd2, 1'b1);
        tick();
        chk_out("rr3", 8'h13, 2'd3, 1'b1);
        tick();
        chk_out("rr4", 8'h10, 2'd0, 1'b1);

        // rr_ptr=1 now; a lone ch2 request moves it to 3.
        in_valid = 4'b0100;
        tick();
        chk_out("rr_to3", 8'h12, 2'd2, 1'b1);

        // Skip and wrap from rr_ptr=3 with in_valid=0110: grants 1, 2, 1.
        in_valid = 4'b0110;
        #1;
        chk("rr_wrap_in_ready", in_ready, 4'b0010);
        tick();
        chk_out("rr_wrap1", 8'h11, 2'd1, 1'b1);
        tick();
        chk_out("rr_wrap2", 8'h12, 2'd2, 1'b1);
        tick();
        chk_out("rr_wrap3", 8'h11, 2'd1, 1'b1);

        // Mid-cycle reset clears the output stage without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_reset", 8'h00, 2'd0, 1'b0);
        chk("async_reset_in_ready", in_ready, 4'b0000);
        tick();
        rst      = 1'b0;
        in_valid = 4'b1111;
        #1;
        chk("post_reset_in_ready", in_ready, 4'b0001);
        tick();
        chk_out("post_reset", 8'h10, 2'd0, 1'b1);

        // N=3: sel=3 names no channel, so nothing is granted or transferred.
        sel3      = 2'd3;
        in_data3  = {8'h22, 8'h21, 8'h20};
        in_valid3 = 3'b111;
        #1;
        chk("n3_sel3_in_ready", in_ready3, 3'b000);
        tick();
        chk("n3_sel3_valid", out_valid3, 1'b0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_in_ready", in_ready3, 3'b100);
        tick();
        chk("n3_sel2_out", out_data3, 8'h22);
        chk("n3_sel2_sel", out_sel3, 2'd2);
        chk("n3_sel2_valid", out_valid3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised, registered N-input, WIDTH-bit multiplexer; successor to the 1-bit 2:1 mux in the ALU datapath.
- Adds per-channel valid/ready handshakes and a one-stage output register.
- Adds a round-robin mode in which the block picks the channel itself.
- Feeds ALU operand and result paths where several sources contend for one bus.

Parameters:
- WIDTH, 8, data width per channel (1..64).
- N, 4, number of input channels (2..16).
- SELW, derived localparam = clog2(N), width of select and channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- IN  input  N*WIDTH  flattened channel data; channel i = IN[i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel data-valid.
- in_ready  output  N  per-channel accept (combinational).
- sel  input  SELW  channel select in direct mode.
- mode  input  1  0 = direct select, 1 = round-robin.
- OUT  output  WIDTH  registered selected data.
- out_sel  output  SELW  index of the channel held in OUT.
- out_valid  output  1  OUT holds valid data.
- out_ready  input  1  downstream accepts OUT.

Behaviour:
- Reset (async, while rst=1): OUT=0, out_sel=0, out_valid=0, rr_ptr=0; in_ready all 0 while rst is high.
- accept = !out_valid || out_ready, i.e. the output stage is empty or draining this cycle.
- A transfer from channel g occurs on a clock edge when accept=1, in_valid[g]=1 and g is granted.
  - Then OUT<=IN[g], out_sel<=g, out_valid<=1.
  - Latency: 1 cycle from input handshake to out_valid.
- If accept=1 and there is no grant: out_valid<=0; OUT and out_sel hold their previous values.
- If accept=0: OUT, out_sel and out_valid hold.
- Only one channel transfers per cycle.
- in_ready[i] = accept && (i == grant) && grant_valid. Every other channel sees in_ready=0.
- Direct mode (mode=0):
  - grant = sel; grant_valid = in_valid[sel] && (sel < N).
  - sel >= N (N not a power of 2): no grant; all in_ready=0.
  - rr_ptr is not updated.
- Round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1 (wraps).
  - grant_valid = |in_valid.
  - On each transfer, rr_ptr <= (grant+1) mod N. The wrap from N-1 goes to 0.
  - With no transfer, rr_ptr holds.
  - sel is ignored.
- mode and sel are sampled combinationally every cycle. Switching mode mid-stream has no effect on data already in OUT. rr_ptr is retained across direct-mode periods.
- Full throughput: with out_ready held at 1, one transfer per cycle.
- Backpressure: with out_ready=0 and out_valid=1, OUT is stable and all in_ready=0.
- Reset asserted mid-operation discards OUT immediately (out_valid=0 asynchronously). The first transfer after release uses rr_ptr=0.

Test Plan:
- Reset: WIDTH=8, N=4, assert rst mid-transfer -> out_valid=0, OUT=0x00, out_sel=0 immediately, not at the next edge.
- Direct mode: mode=0, sel=2, IN ch2=0xA5, in_valid=4'b0100, out_ready=1.
  - in_ready=4'b0100.
  - Next cycle: OUT=0xA5, out_sel=2, out_valid=1.
  - Then sel=1 with in_valid[1]=0 -> out_valid drops to 0 one cycle later; OUT holds 0xA5.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new data on the selected channel -> OUT unchanged and in_ready=0 throughout. out_ready=1 -> new data appears 1 cycle later.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1, channel data 0x10/0x11/0x12/0x13 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; OUT follows.
- Round-robin skip and wrap: rr_ptr=3, in_valid=4'b0110 -> grant 1, then rr_ptr=2 -> grant 2, then rr_ptr=3 -> grant 1.
- Non-power-of-2 N=3, mode=0, sel=3, in_valid=3'b111 -> in_ready=0 and no transfer.
